muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS32 pipeline. It sequences 32-step shift-add multiplication and restoring division for MULT/MULTU/DIV/DIVU off the EX stage. It holds HI/LO for MFHI/MFLO/MTHI/MTLO. It exports `Busy` so the hazard unit can stall any HI/LO access or new mul/div issue while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported; the parameter exists for constant sizing.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  issue an operation; sampled only when idle.
- `Op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `In1`  in  32  multiplicand or dividend (rs).
- `In2`  in  32  multiplier or divisor (rt).
- `HiWrite`  in  1  MTHI strobe.
- `LoWrite`  in  1  MTLO strobe.
- `WriteData`  in  32  data for MTHI/MTLO.
- `Hi`  out  32  HI register; reset 0.
- `Lo`  out  32  LO register; reset 0.
- `Busy`  out  1  operation in flight; reset 0.
- `Done`  out  1  one-cycle pulse after HI/LO are updated by an operation; reset 0.

## Operation
FSM states:
- IDLE. `Start`=1 at an edge latches the operation and moves to CALC. The latch captures:
  - the magnitudes of the operands (negated if signed op and bit 31 set);
  - the result signs;
  - `Op`.
- CALC. Performs 32 iterations with a 5-bit counter 0..31. After iteration 31 it moves to FIX.
- FIX. Applies the signs and writes HI/LO. Pulses `Done` and returns to IDLE.

Arithmetic:
- Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier, one bit per cycle.
  - Signed product sign = In1[31]^In2[31].
  - Result: HI = [63:32], LO = [31:0].
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle.
  - Quotient sign = In1[31]^In2[31]; remainder sign = In1[31].
  - Result: LO = quotient, HI = remainder.
- Divide by zero (both DIV and DIVU): LO = 32'hFFFFFFFF and HI = In1 as latched (unmodified dividend). Full latency still applies.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No trap.

MTHI/MTLO and conflicts:
- `HiWrite`/`LoWrite` in IDLE update Hi/Lo at the next edge. Both may be asserted together.
- While `Busy`=1, `Start`, `HiWrite` and `LoWrite` are ignored. The hazard unit must stall.
- `Start` together with `HiWrite`/`LoWrite` in IDLE: `Start` wins and the writes are dropped.

Reset:
- `reset` at any time, including mid-operation, forces the following immediately (asynchronously):
  - state IDLE and counter 0;
  - `Hi` = `Lo` = 0;
  - `Busy` = `Done` = 0.
- The aborted operation leaves no trace.

## Timing
- `Start` sampled at edge E0 gives `Busy`=1 after E0.
- CALC runs iterations at edges E1..E32; the state is FIX after E32.
- E33 writes Hi/Lo, sets `Done`=1 for exactly one cycle and clears `Busy`.
- `Busy` is high for 33 cycles. Hi/Lo hold the result from E33 on.
- Back-to-back: a `Start` sampled at E34 is accepted, giving a 34-cycle issue interval.
- MTHI/MTLO latency is 1 edge.
- Hi/Lo never change during CALC; the old values stay readable until E33.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
Shared package `muldiv_pkg` holds:
- `Op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
- the FSM state encoding (IDLE, CALC, FIX);
- `ITERS` = 32;
- the divide-by-zero LO constant 32'hFFFFFFFF.

One combinational sub-module, `muldiv_step`, computes one iteration for either mode:
- multiply mode: conditional add and shift;
- divide mode: trial subtract, restore and shift.

The FSM, counter, sign fix-up and HI/LO registers live in the top.

## Test plan
- MULTU FFFFFFFF × FFFFFFFF → after E33 Hi=FFFFFFFE, Lo=00000001. `Busy` high 33 cycles; `Done` is a single pulse.
- MULT FFFFFFFD (−3) × 00000007 → Hi=FFFFFFFF, Lo=FFFFFFEB. Then immediately (E34) MULT 00000000 × 12345678 → Hi=Lo=0 at E67.
- Divide cases:
  - DIV FFFFFFF9 (−7) / 00000002 → Lo=FFFFFFFD, Hi=FFFFFFFF.
  - DIVU 00000007 / 00000002 → Lo=3, Hi=1.
  - DIV 80000000 / FFFFFFFF → Lo=80000000, Hi=0.
- DIVU 0000ABCD / 0 → Lo=FFFFFFFF, Hi=0000ABCD, after the same 33-cycle latency.
- MTHI 12345678 in IDLE → Hi=12345678 next edge. Then, during a running MULT:
  - MTLO is ignored.
  - A `Start` at cycle 5 is ignored; the result matches the first operation only.
- `reset` pulsed at cycle 10 of a DIV → Hi=Lo=0, `Busy`=0, `Done` never pulses. A subsequent MULTU 3×5 gives Lo=0000000F, Hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  localparam int          ITERS   = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// The 65-bit state is {carry/rem[32], hi/rem[31:0], lo/quotient}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        div_i,
  input  logic [64:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [64:0] acc_o
);

  logic [32:0] sum_s;
  logic [33:0] shifted_s;
  logic [33:0] diff_s;

  // Multiply adds on the multiplier LSB; divide keeps the trial difference only when it did not borrow.
  always_comb begin
    sum_s     = acc_i[64:32] + {1'b0, opnd_i};
    shifted_s = acc_i[64:31];
    diff_s    = shifted_s - {2'b00, opnd_i};
    acc_o     = acc_i;
    if (div_i) begin
      if (diff_s[33] == 1'b0) begin
        acc_o = {diff_s[32:0], acc_i[30:0], 1'b1};
      end else begin
        acc_o = {shifted_s[32:0], acc_i[30:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {1'b0, sum_s, acc_i[31:1]};
      end else begin
        acc_o = {2'b00, acc_i[63:32], acc_i[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// MIPS32 multiply/divide unit: IDLE/CALC/FIX sequencer, sign fix-up and the HI/LO registers.
// Operands are latched as magnitudes; signs are re-applied once in FIX.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [64:0] step_s;
  logic        signed_s;
  logic [31:0] mag1_s, mag2_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;

  muldiv_step u_step (
    .div_i  (op_is_div(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_s)
  );

  // Next-state, datapath capture, sign fix-up and HI/LO write selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    signed_s = ~Op[0];
    mag1_s   = magnitude(In1, signed_s);
    mag2_s   = magnitude(In2, signed_s);
    prod_s   = neg_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
    quo_s    = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_s    = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CALC;
          op_d    = op_e'(Op);
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          neg_d   = signed_s & (In1[31] ^ In2[31]);
          rneg_d  = signed_s & In1[31];
          div0_d  = (In2 == 32'd0);
          if (Op[1]) begin
            acc_d  = {33'd0, mag1_s};
            opnd_d = mag2_s;
          end else begin
            acc_d  = {33'd0, mag2_s};
            opnd_d = mag1_s;
          end
        end else begin
          if (HiWrite) begin
            hi_d = WriteData;
          end else begin
            hi_d = hi_q;
          end
          if (LoWrite) begin
            lo_d = WriteData;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      CALC: begin
        acc_d = step_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERS - 1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        // A zero divisor yields an all-ones quotient and the dividend itself as remainder.
        if (op_is_div(op_q)) begin
          hi_d = rem_s;
          if (div0_q) begin
            lo_d = DIV0_LO;
          end else begin
            lo_d = quo_s;
          end
        end else begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= 5'd0;
      acc_q   <= 65'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: expected HI/LO queued at issue, checked on Done.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] In1, In2, WriteData;
  logic        HiWrite, LoWrite;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        scoreboard[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  muldiv_hilo_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .In1(In1), .In2(In2),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    return e;
  endfunction

  // Reference arithmetic in plain SystemVerilog operators.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sbv;
    exp_t e;
    sa  = a;
    sbv = b;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e = mk(sp[63:32], sp[31:0]);
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        e = mk(up[63:32], up[31:0]);
      end
      2'b10: begin
        if (b == 32'd0) e = mk(a, 32'hFFFF_FFFF);
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e = mk(32'd0, 32'h8000_0000);
        else e = mk(32'(sa % sbv), 32'(sa / sbv));
      end
      default: begin
        if (b == 32'd0) e = mk(a, 32'hFFFF_FFFF);
        else e = mk(a % b, a / b);
      end
    endcase
    return e;
  endfunction

  // Called on a negative edge; leaves the bench on the negedge after the accepting edge.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op    = op;
    In1   = a;
    In2   = b;
    Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start   = 1'b0;
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    check_eq({tag, "_busy_on"}, 32'(Busy), 32'd1);
    check_eq({tag, "_hi_held"}, Hi, model_hi);
  endtask

  task automatic wait_done(input string tag, input bit disturb);
    int   n      = 0;
    int   cycles = 1;
    exp_t e;
    while (Done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (Busy) cycles++;
      if (disturb) begin
        if (n == 2) begin
          LoWrite   = 1'b1;
          WriteData = 32'hDEAD_BEEF;
        end else if (n == 3) begin
          LoWrite = 1'b0;
        end
        if (n == 5) begin
          Start = 1'b1;
          Op    = 2'b11;
          In1   = 32'd100;
          In2   = 32'd7;
        end else if (n == 6) begin
          Start = 1'b0;
        end
      end
      if (n == 16) begin
        check_eq({tag, "_mid_hi"}, Hi, model_hi);
        check_eq({tag, "_mid_lo"}, Lo, model_lo);
      end
    end
    check_eq({tag, "_latency"}, 32'(n), 32'd33);
    check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
    check_eq({tag, "_sb_depth"}, 32'(scoreboard.size()), 32'd1);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      check_eq({tag, "_hi"}, Hi, e.hi);
      check_eq({tag, "_lo"}, Lo, e.lo);
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    scoreboard.push_back(e);
    issue(tag, op, a, b);
    wait_done(tag, 1'b0);
  endtask

  initial begin
    int   done_seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; Start = 1'b0; Op = 2'b00; In1 = 32'd0; In2 = 32'd0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_hi", Hi, 32'd0);
    check_eq("rst_lo", Lo, 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_done", 32'(Done), 32'd0);

    HiWrite = 1'b1; WriteData = 32'h1234_5678;
    @(negedge clk);
    HiWrite = 1'b0;
    model_hi = 32'h1234_5678;
    check_eq("mthi_hi", Hi, model_hi);
    check_eq("mthi_lo", Lo, 32'd0);
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hA5A5_0F0F;
    @(negedge clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    model_hi = 32'hA5A5_0F0F; model_lo = 32'hA5A5_0F0F;
    check_eq("mt_both_hi", Hi, model_hi);
    check_eq("mt_both_lo", Lo, model_lo);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001));
    @(negedge clk);
    check_eq("done_pulse_width", 32'(Done), 32'd0);
    check_eq("multu_max_hold", Hi, 32'hFFFF_FFFE);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB));
    check_eq("b2b_done_at_issue", 32'(Done), 32'd1);
    run_op("mult_zero_b2b", 2'b00, 32'h0000_0000, 32'h1234_5678, mk(32'd0, 32'd0));

    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD));
    run_op("divu_7_2", 2'b11, 32'h0000_0007, 32'h0000_0002, mk(32'h0000_0001, 32'h0000_0003));
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0000_0000, 32'h8000_0000));
    run_op("divu_by0", 2'b11, 32'h0000_ABCD, 32'h0000_0000, mk(32'h0000_ABCD, 32'hFFFF_FFFF));
    run_op("div_by0_neg", 2'b10, 32'hFFFF_0001, 32'h0000_0000, mk(32'hFFFF_0001, 32'hFFFF_FFFF));

    // Writes and a second Start while busy must be ignored.
    scoreboard.push_back(mk(32'd0, 32'd30));
    issue("mult_disturb", 2'b00, 32'd5, 32'd6);
    wait_done("mult_disturb", 1'b1);
    repeat (3) @(negedge clk);
    check_eq("disturb_no_restart", 32'(Busy), 32'd0);
    check_eq("disturb_lo_kept", Lo, 32'd30);

    HiWrite = 1'b1; WriteData = 32'hCAFE_F00D;
    run_op("start_wins", 2'b01, 32'd2, 32'd3, mk(32'd0, 32'd6));

    issue("div_abort", 2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("abort_hi", Hi, 32'd0);
    check_eq("abort_lo", Lo, 32'd0);
    check_eq("abort_busy", 32'(Busy), 32'd0);
    check_eq("abort_done", 32'(Done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) done_seen++;
    end
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    check_eq("abort_idle", 32'(Busy), 32'd0);
    run_op("multu_3x5", 2'b01, 32'd3, 32'd5, mk(32'd0, 32'h0000_000F));

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
